// File: rtl/operand_stack.sv
// rtl/operand_stack.sv - LIFO operand stack with combinational top/next and single-edge replace
// Storage is never cleared; count masks stale entries from top/next.

module operand_stack #(
    parameter int DATA_SIZE = 11,
    parameter int DEPTH     = 16,
    parameter int PTR_SIZE  = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_SIZE-1:0] in,
    input  logic                 push,
    input  logic                 pop,
    output logic [DATA_SIZE-1:0] top,
    output logic [DATA_SIZE-1:0] next,
    output logic [PTR_SIZE-1:0]  count,
    output logic                 empty,
    output logic                 full,
    output logic                 overflow,
    output logic                 underflow
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_SIZE-1:0] mem_q [DEPTH];
    logic [PTR_SIZE-1:0]  count_q, count_d;
    logic                 overflow_q, overflow_d;
    logic                 underflow_q, underflow_d;
    logic                 wr_en;
    logic [AW-1:0]        wr_addr;
    logic [AW-1:0]        top_idx, next_idx;
    logic                 is_empty, is_full;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == PTR_SIZE'(DEPTH));
    assign top_idx  = AW'(count_q - PTR_SIZE'(1));
    assign next_idx = AW'(count_q - PTR_SIZE'(2));

    always_comb begin
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        wr_en       = 1'b0;
        wr_addr     = count_q[AW-1:0];
        case ({push, pop})
            2'b10: begin
                if (!is_full) begin
                    wr_en   = 1'b1;
                    wr_addr = count_q[AW-1:0];
                    count_d = count_q + PTR_SIZE'(1);
                end else begin
                    overflow_d = 1'b1;
                end
            end
            2'b01: begin
                if (!is_empty) begin
                    count_d = count_q - PTR_SIZE'(1);
                end else begin
                    underflow_d = 1'b1;
                end
            end
            2'b11: begin
                // Replace overwrites the top in place; on empty it degrades to a push.
                wr_en = 1'b1;
                if (!is_empty) begin
                    wr_addr = top_idx;
                end else begin
                    wr_addr     = '0;
                    count_d     = PTR_SIZE'(1);
                    underflow_d = 1'b1;
                end
            end
            default: ;
        endcase
        if (rst) begin
            wr_en = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= in;
        end
    end

    assign top       = is_empty ? '0 : mem_q[top_idx];
    assign next      = (count_q < PTR_SIZE'(2)) ? '0 : mem_q[next_idx];
    assign count     = count_q;
    assign empty     = is_empty;
    assign full      = is_full;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule
